// File: rtl/wb_cfg_bridge.sv
// Wishbone register window that loads/stores wide words into NUM_TGT generic target memories.
// Optional per-byte-lane write masking is enabled by defining CFG_BYTE_SEL_EN.
module wb_cfg_bridge #(
  parameter int unsigned NUM_TGT            = 3,
  parameter int unsigned TGT_SEL_BW         = 3,
  parameter int unsigned TGT_ADDR_BW        = 8,
  parameter int unsigned DATA_WORDS         = 4,
  parameter int unsigned RD_LATENCY         = 1,
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_dat_i,
  input  logic [31:0]                     wbs_adr_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  output logic [NUM_TGT-1:0]              tgt_rd_en_o,
  output logic [NUM_TGT-1:0]              tgt_wr_en_o,
  output logic [TGT_ADDR_BW-1:0]          tgt_addr_o,
  output logic [32*DATA_WORDS-1:0]        tgt_wr_data_o,
  input  logic [NUM_TGT*32*DATA_WORDS-1:0] tgt_rd_data_i
);

  localparam int unsigned DW      = 32 * DATA_WORDS;
  localparam int unsigned AW      = TGT_ADDR_BW + TGT_SEL_BW;
  localparam int unsigned DIdxW   = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [3:0]  LatInit = 4'(RD_LATENCY - 1);

`ifdef CFG_BYTE_SEL_EN
  localparam bit ByteSelEn = 1'b1;
`else
  localparam bit ByteSelEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StWrite, StRdReq, StRdWait, StCapture} state_e;

  state_e                         state_q;
  logic [AW-1:0]                  addr_q;
  logic                           autoinc_q;
  logic                           err_q;
  logic                           ovr_q;
  logic [DATA_WORDS-1:0][31:0]    data_q;
  logic [3:0]                     cnt_q;
  logic [TGT_SEL_BW-1:0]          tgt_q;

  logic                  access, wr_acc, busy;
  logic [31:0]           offset;
  logic                  hit_addr, hit_ctrl, hit_status, hit_data;
  logic [DIdxW-1:0]      didx;
  logic [31:0]           wmask;
  logic                  cmd_lane, cmd_store, cmd_load;
  logic [TGT_SEL_BW-1:0] sel_tgt;
  logic                  tgt_ok;
  logic [NUM_TGT-1:0]    onehot;
  logic [DW-1:0]         rd_slice;
  logic [31:0]           rdata;

  assign access     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_acc     = access & wbs_we_i;
  assign busy       = (state_q != StIdle);
  assign offset     = wbs_adr_i - WISHBONE_BASE_ADDR;
  assign hit_addr   = (offset == 32'h0);
  assign hit_ctrl   = (offset == 32'h4);
  assign hit_status = (offset == 32'h8);
  assign hit_data   = (offset >= 32'h10) && (offset < 32'(16 + 4 * DATA_WORDS)) &&
                      (offset[1:0] == 2'b00);
  assign didx       = DIdxW'((offset - 32'h10) >> 2);

  // Lanes with sel=0 are preserved only when byte-lane masking is built in.
  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{wbs_sel_i[b] | ~ByteSelEn}};
    end
  end

  assign cmd_lane  = wbs_sel_i[0] | ~ByteSelEn;
  assign cmd_store = wr_acc & hit_ctrl & cmd_lane & wbs_dat_i[0];
  assign cmd_load  = wr_acc & hit_ctrl & cmd_lane & wbs_dat_i[1];
  assign sel_tgt   = addr_q[AW-1:TGT_ADDR_BW];
  assign tgt_ok    = 32'(sel_tgt) < NUM_TGT;

  always_comb begin
    onehot   = '0;
    rd_slice = '0;
    for (int unsigned t = 0; t < NUM_TGT; t++) begin
      onehot[t] = (32'(sel_tgt) == t);
      if (32'(tgt_q) == t) rd_slice = tgt_rd_data_i[t*DW +: DW];
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_addr)        rdata = 32'(addr_q);
    else if (hit_ctrl)   rdata = {29'b0, autoinc_q, 2'b00};
    else if (hit_status) rdata = {29'b0, ovr_q, err_q, busy};
    else if (hit_data)   rdata = data_q[didx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      autoinc_q     <= 1'b0;
      err_q         <= 1'b0;
      ovr_q         <= 1'b0;
      data_q        <= '0;
      cnt_q         <= '0;
      tgt_q         <= '0;
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      tgt_rd_en_o   <= '0;
      tgt_wr_en_o   <= '0;
      tgt_addr_o    <= '0;
      tgt_wr_data_o <= '0;
    end else begin
      wbs_ack_o <= wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : 32'h0;

      if (wr_acc) begin
        if (hit_addr) addr_q <= AW'((32'(addr_q) & ~wmask) | (wbs_dat_i & wmask));
        if (hit_ctrl) autoinc_q <= wmask[2] ? wbs_dat_i[2] : autoinc_q;
        if (hit_status) begin
          err_q <= 1'b0;
          ovr_q <= 1'b0;
        end
        if (hit_data) data_q[didx] <= (data_q[didx] & ~wmask) | (wbs_dat_i & wmask);
      end

      if ((cmd_store || cmd_load) && busy) ovr_q <= 1'b1;

      // FSM assignments come last so capture and auto-increment win over bus writes.
      unique case (state_q)
        StIdle: begin
          if (cmd_store || cmd_load) begin
            if (!tgt_ok) begin
              err_q <= 1'b1;
            end else begin
              tgt_q         <= sel_tgt;
              tgt_addr_o    <= addr_q[TGT_ADDR_BW-1:0];
              tgt_wr_data_o <= data_q;
              if (cmd_store) begin
                state_q     <= StWrite;
                tgt_wr_en_o <= onehot;
              end else begin
                state_q     <= StRdReq;
                tgt_rd_en_o <= onehot;
                cnt_q       <= LatInit;
              end
            end
          end
        end
        StWrite: begin
          tgt_wr_en_o <= '0;
          state_q     <= StIdle;
          if (autoinc_q) addr_q <= addr_q + 1'b1;
        end
        StRdReq: begin
          tgt_rd_en_o <= '0;
          state_q     <= (RD_LATENCY == 1) ? StCapture : StRdWait;
        end
        StRdWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StCapture;
        end
        StCapture: begin
          data_q  <= rd_slice;
          state_q <= StIdle;
          if (autoinc_q) addr_q <= addr_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cfg_bridge.sv
// Bench for wb_cfg_bridge: transaction-level model plus per-cycle compare, directed then random.
module tb_wb_cfg_bridge;

  localparam int          L    = 3;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef CFG_BYTE_SEL_EN
  localparam bit BYTE_SEL = 1'b1;
`else
  localparam bit BYTE_SEL = 1'b0;
`endif

  bit           clk;
  logic         rst_i;
  logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i, wbs_adr_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [2:0]   tgt_rd_en_o, tgt_wr_en_o;
  logic [7:0]   tgt_addr_o;
  logic [127:0] tgt_wr_data_o;
  logic [383:0] tgt_rd_data_i;

  always #5 clk = ~clk;

  wb_cfg_bridge #(
    .NUM_TGT   (3),
    .RD_LATENCY(L)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .wbs_stb_i    (wbs_stb_i),
    .wbs_cyc_i    (wbs_cyc_i),
    .wbs_we_i     (wbs_we_i),
    .wbs_sel_i    (wbs_sel_i),
    .wbs_dat_i    (wbs_dat_i),
    .wbs_adr_i    (wbs_adr_i),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .tgt_rd_en_o  (tgt_rd_en_o),
    .tgt_wr_en_o  (tgt_wr_en_o),
    .tgt_addr_o   (tgt_addr_o),
    .tgt_wr_data_o(tgt_wr_data_o),
    .tgt_rd_data_i(tgt_rd_data_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model: architectural registers plus the cycle on which the running command finishes.
  logic [10:0]  m_addr = '0;
  logic         m_autoinc = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
  logic [31:0]  m_data [4];
  logic [127:0] mem [3][256];
  int           m_last = -1;
  bit           m_is_load;
  int           m_tgt, m_laddr;
  // Expected outputs for the next cycle.
  logic         e_ack = 1'b0, e_dat_chk = 1'b0;
  logic [31:0]  e_dat;
  logic [2:0]   e_wr = '0, e_rd = '0;
  logic [7:0]   e_taddr;
  logic [127:0] e_wdata;
  // Target responder state.
  int           pend_c = -1, pend_t, pend_a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b] | !BYTE_SEL}};
    return m;
  endfunction

  function automatic logic [31:0] reg_read(input logic [31:0] off, input logic busy);
    if (off == 32'h0) return {21'b0, m_addr};
    if (off == 32'h4) return {29'b0, m_autoinc, 2'b00};
    if (off == 32'h8) return {29'b0, m_ovr, m_err, busy};
    if (off >= 32'h10 && off < 32'h20 && off[1:0] == 2'b00) return m_data[int'((off - 32'h10) >> 2)];
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0]  off, mask;
    logic         acc, busy, lane0, o_auto;
    logic [10:0]  o_addr;
    logic [127:0] snap;
    busy = (cyc_n <= m_last);
    e_wr = '0;
    e_rd = '0;
    if (rst_i) begin
      m_addr = '0; m_autoinc = 0; m_err = 0; m_ovr = 0; m_last = -1;
      for (int k = 0; k < 4; k++) m_data[k] = '0;
      e_ack = 0; e_dat_chk = 0;
      return;
    end
    off    = wbs_adr_i - BASE;
    mask   = lane_mask(wbs_sel_i);
    lane0  = wbs_sel_i[0] | !BYTE_SEL;
    acc    = wbs_stb_i & wbs_cyc_i & !e_ack;
    o_addr = m_addr;
    o_auto = m_autoinc;
    for (int k = 0; k < 4; k++) snap[32*k +: 32] = m_data[k];
    e_dat_chk = acc & !wbs_we_i;
    e_dat     = reg_read(off, busy);
    if (acc && wbs_we_i) begin
      if (off == 32'h0) m_addr = 11'(({21'b0, m_addr} & ~mask) | (wbs_dat_i & mask));
      else if (off == 32'h4) m_autoinc = mask[2] ? wbs_dat_i[2] : m_autoinc;
      else if (off == 32'h8) begin m_err = 0; m_ovr = 0; end
      else if (off >= 32'h10 && off < 32'h20 && off[1:0] == 2'b00) begin
        m_data[int'((off - 32'h10) >> 2)] =
          (m_data[int'((off - 32'h10) >> 2)] & ~mask) | (wbs_dat_i & mask);
      end
    end
    if (cyc_n == m_last) begin
      if (m_is_load) for (int k = 0; k < 4; k++) m_data[k] = mem[m_tgt][m_laddr][32*k +: 32];
      if (o_auto) m_addr = o_addr + 11'd1;
    end
    if (acc && wbs_we_i && off == 32'h4 && lane0 && (wbs_dat_i[0] || wbs_dat_i[1])) begin
      if (busy) m_ovr = 1;
      else if (o_addr[10:8] >= 3'd3) m_err = 1;
      else begin
        m_tgt   = int'(o_addr[10:8]);
        m_laddr = int'(o_addr[7:0]);
        e_taddr = o_addr[7:0];
        if (wbs_dat_i[0]) begin
          m_is_load = 0;
          m_last    = cyc_n + 1;
          mem[m_tgt][m_laddr] = snap;
          e_wdata   = snap;
          e_wr      = 3'(1 << m_tgt);
        end else begin
          m_is_load = 1;
          m_last    = cyc_n + 1 + L;
          e_rd      = 3'(1 << m_tgt);
        end
      end
    end
    e_ack = acc;
  endtask

  // Target memories: respond exactly L cycles after a read strobe, junk otherwise.
  task automatic respond();
    logic [383:0] v;
    if (tgt_rd_en_o != 3'b000) begin
      for (int t = 0; t < 3; t++) if (tgt_rd_en_o[t]) pend_t = t;
      pend_a = int'(tgt_addr_o);
      pend_c = cyc_n + L;
    end
    for (int w = 0; w < 12; w++) v[32*w +: 32] = $urandom;
    if (cyc_n == pend_c) v[128*pend_t +: 128] = mem[pend_t][pend_a];
    tgt_rd_data_i = v;
  endtask

  task automatic compare();
    check("ack", 128'(wbs_ack_o), 128'(e_ack));
    if (e_ack && e_dat_chk) check("rdata", 128'(wbs_dat_o), 128'(e_dat));
    check("wr_en", 128'(tgt_wr_en_o), 128'(e_wr));
    check("rd_en", 128'(tgt_rd_en_o), 128'(e_rd));
    if (e_wr != 0 || e_rd != 0) check("tgt_addr", 128'(tgt_addr_o), 128'(e_taddr));
    if (e_wr != 0) check("wr_data", tgt_wr_data_o, e_wdata);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc_n++;
    respond();
    compare();
  endtask

  task automatic idle(input int n);
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    repeat (n) tick();
  endtask

  task automatic wb_access(input logic we, input logic [31:0] off, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = we;
    wbs_adr_i = BASE + off; wbs_dat_i = dat; wbs_sel_i = sel;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wbs_ack_o === 1'b1) break;
    end
    check("ack_seen", 128'(wbs_ack_o), 128'(1'b1));
    rd = wbs_dat_o;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat);
    logic [31:0] unused_rd;
    wb_access(1'b1, off, dat, 4'hF, unused_rd);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb_access(1'b0, off, 32'h0, 4'hF, r);
    check(name, 128'(r), 128'(exp));
  endtask

  logic [7:0] ai_addr [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};
  logic [2:0] ai_we   [4] = '{3'b001, 3'b010, 3'b010, 3'b010};

  initial begin
    for (int t = 0; t < 3; t++)
      for (int a = 0; a < 256; a++) mem[t][a] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) m_data[k] = '0;
    rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 4'hF; wbs_dat_i = '0; wbs_adr_i = BASE; tgt_rd_data_i = '0;
    tick();
    tick();
    rst_i = 0;
    check("rst_ack", 128'(wbs_ack_o), 128'(0));
    check("rst_dat", 128'(wbs_dat_o), 128'(0));
    check("rst_wr_en", 128'(tgt_wr_en_o), 128'(0));
    check("rst_rd_en", 128'(tgt_rd_en_o), 128'(0));

    // Held strobe: ack alternates, never two cycles in a row.
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_adr_i = BASE + 32'h8;
    tick(); check("ack_pulse1", 128'(wbs_ack_o), 128'(1));
    check("status_rst", 128'(wbs_dat_o), 128'(0));
    tick(); check("ack_gap", 128'(wbs_ack_o), 128'(0));
    tick(); check("ack_pulse2", 128'(wbs_ack_o), 128'(1));
    idle(1);

    // Store to target 1, local 0x05.
    wr(32'h0, 32'h105);
    wr(32'h10, 32'h1111_1111); wr(32'h14, 32'h2222_2222);
    wr(32'h18, 32'h3333_3333); wr(32'h1C, 32'h4444_4444);
    wr(32'h4, 32'h1);
    check("store_we", 128'(tgt_wr_en_o), 128'(3'b010));
    check("store_addr", 128'(tgt_addr_o), 128'(8'h05));
    check("store_data", tgt_wr_data_o, 128'h44444444_33333333_22222222_11111111);
    idle(2);

    // Load from target 2, local 0x0A.
    mem[2][8'h0A] = {96'h0, 32'hDEAD_BEEF};
    wr(32'h0, 32'h20A);
    wr(32'h4, 32'h2);
    check("load_re", 128'(tgt_rd_en_o), 128'(3'b100));
    rd_chk("load_busy", 32'h8, 32'h1);
    idle(4);
    rd_chk("load_d0", 32'h10, 32'hDEAD_BEEF);
    rd_chk("load_d1", 32'h14, 32'h0);
    rd_chk("load_idle", 32'h8, 32'h0);

    // Auto-increment across the target boundary.
    wr(32'h0, 32'h0FF);
    for (int i = 0; i < 4; i++) begin
      wr(32'h4, 32'h5);
      check("ai_we", 128'(tgt_wr_en_o), 128'(ai_we[i]));
      check("ai_addr", 128'(tgt_addr_o), 128'(ai_addr[i]));
      idle(2);
      if (i == 0) rd_chk("ai_addr_rb", 32'h0, 32'h100);
    end
    wr(32'h4, 32'h0);

    // Overrun, then out-of-range target, then clear.
    wr(32'h0, 32'h20A);
    wr(32'h4, 32'h2);
    wr(32'h4, 32'h2);
    idle(5);
    rd_chk("ovr", 32'h8, 32'h4);
    wr(32'h0, 32'h300);
    wr(32'h4, 32'h1);
    check("err_no_we", 128'(tgt_wr_en_o), 128'(0));
    rd_chk("err", 32'h8, 32'h6);
    wr(32'h8, 32'h0);
    rd_chk("status_clr", 32'h8, 32'h0);

    // Byte-lane writes.
    wr(32'h10, 32'hAABB_CCDD);
    begin
      logic [31:0] unused_rd;
      wb_access(1'b1, 32'h10, 32'h1122_3344, 4'b0101, unused_rd);
    end
    rd_chk("byte_sel", 32'h10, BYTE_SEL ? 32'hAA22_CC44 : 32'h1122_3344);

    // Reset while waiting on a read.
    wr(32'h0, 32'h10A);
    wr(32'h4, 32'h2);
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    idle(6);
    rd_chk("rst_mid_d0", 32'h10, 32'h0);
    rd_chk("rst_mid_st", 32'h8, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst_i     = ($urandom_range(0, 499) == 0);
      wbs_stb_i = ($urandom_range(0, 3) != 0);
      wbs_cyc_i = ($urandom_range(0, 7) != 0);
      wbs_we_i  = ($urandom_range(0, 2) != 0);
      wbs_sel_i = 4'($urandom);
      wbs_dat_i = $urandom;
      r = $urandom_range(0, 11);
      case (r)
        0, 1: begin
          wbs_adr_i = BASE;
          wbs_dat_i = {21'b0, 3'($urandom_range(0, 3)), 8'($urandom)};
        end
        2, 3, 4: begin
          wbs_adr_i = BASE + 32'h4;
          wbs_dat_i = 32'($urandom_range(0, 7));
        end
        5:          wbs_adr_i = BASE + 32'h8;
        6, 7, 8, 9: wbs_adr_i = BASE + 32'h10 + 32'(4 * (r - 6));
        10:         wbs_adr_i = BASE + 32'hC;
        default:    wbs_adr_i = ($urandom_range(0, 1) != 0) ? BASE + 32'h20 : 32'h2000_0004;
      endcase
      tick();
    end
    rst_i = 0;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
